cnt_snapshot_fifo: RTL and testbench
====================================

Name: cnt_snapshot_fifo

Overview:
- Downstream consumer of the 8-bit free-running counter's `cnt` output.
- On each rising edge of a trigger input, captures the current count into a small FIFO.
- Presents captured values to the next stage over a valid/ready handshake.
- Flags lost captures with a sticky overflow bit; used for timestamping events against the counter.

Parameters:
- WIDTH, 8: width of captured count; matches counter output.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- AW, 2: pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- cnt_in  input  WIDTH  counter value, sampled on capture
- trig  input  1  event input, synchronous to clk; rising edge requests capture
- out_data  output  WIDTH  head-of-FIFO count value
- out_valid  output  1  FIFO non-empty; out_data is meaningful
- out_ready  input  1  consumer accepts head when out_valid & out_ready
- level  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a capture was dropped because FIFO was full
- clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, level=0.
  - out_valid=0, out_data=0, overflow=0.
  - All storage entries cleared to 0.
  - trig_q=1, so a trig held high through reset release does not create a capture.
  - Reset mid-operation discards all stored entries immediately.
- Edge detect:
  - trig_q registers trig every cycle.
  - cap = trig & ~trig_q.
  - A trig held high yields exactly one capture.
  - Low-high-low-high on consecutive cycles yields captures on each high cycle that follows a low.
- Push: on a clock edge with cap=1, store cnt_in as seen in that cycle (no extra delay) at wr_ptr and advance wr_ptr mod DEPTH, if allowed.
- Pop: on a clock edge with out_valid & out_ready, rd_ptr advances mod DEPTH.
- Push allowed when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle (simultaneous push+pop while full is legal; level stays DEPTH).
- Dropped capture (cap=1, level==DEPTH, no pop):
  - Captured value discarded; FIFO contents unchanged.
  - overflow<=1.
- Level update:
  - Push only: level+1.
  - Pop only: level-1.
  - Both: unchanged.
  - Neither: unchanged.
- Outputs:
  - out_valid = (level!=0).
  - out_data = mem[rd_ptr], updated the cycle after rd_ptr moves.
- Latency: capture at edge N into empty FIFO -> out_valid=1 and out_data=captured value after edge N (visible in cycle N+1).
- Simultaneous push and pop with level==0: no pass-through; pop is impossible since out_valid=0, so level becomes 1.
- Overflow: sticky until clr_ovf=1 at a clock edge. If clr_ovf and a new drop occur in the same cycle, set wins (overflow=1).
- Pointer wrap: DEPTH-1 -> 0. Full/empty are distinguished by level, not by pointer equality.
- cnt_in wrap (255->0) needs no special handling; values are stored verbatim.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset release with trig=1 held, cnt_in=8'h10 -> no capture; level=0, out_valid=0, overflow=0.
- Counter enabled counting from 0, trig pulse 1 cycle when cnt_in=8'h05, out_ready=0 -> next cycle out_valid=1, out_data=8'h05, level=1.
- Five single-cycle trig pulses at cnt_in=3,6,9,12,15, out_ready=0 -> level=4, overflow=1. Then with out_ready=1 the pops return 3,6,9,12 in order; 15 is lost.
- FIFO full (level=4), trig edge at cnt_in=8'h40 with out_ready=1 same cycle -> no overflow, level stays 4, value 8'h40 appears as the last entry popped.
- overflow=1, clr_ovf=1 in the same cycle as a dropped capture -> overflow remains 1. clr_ovf=1 alone next cycle -> overflow=0.
- Captures across counter wrap at cnt_in=8'hFE and 8'h01, then rst=0 pulsed asynchronously mid-stream with level=2 -> level=0, out_valid=0, out_data=0 immediately. After release, out_ready=1 produces no data.

Source files
------------

// File: rtl/cnt_snapshot_fifo_if.sv
// Valid/ready output channel carrying captured counter values
// from the snapshot FIFO to its consumer.
interface cnt_snapshot_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/cnt_snapshot_fifo.sv
// Captures the free-running count on each rising edge of trig into a small FIFO,
// drains it over a valid/ready channel and flags dropped captures as sticky overflow.
module cnt_snapshot_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   cnt_in,
  input  logic               trig,
  input  logic               clr_ovf,
  output logic [AW:0]        level,
  output logic               overflow,
  cnt_snapshot_fifo_if.master bus
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             trig_q;
  logic             cap;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;

  // trig_q resets high so a trig already asserted at reset release is not an edge
  assign cap  = trig & ~trig_q;
  assign pop  = bus.out_valid & bus.out_ready;
  assign full = (level == FULL_LEVEL);
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  assign bus.out_valid = (level != '0);
  assign bus.out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      trig_q <= trig;

      if (push) begin
        mem[wr_ptr] <= cnt_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end

      // a new drop takes priority over a clear in the same cycle
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnt_snapshot_fifo.sv
// Self-checking bench for cnt_snapshot_fifo: queue-based reference model,
// per-cycle comparison, directed scenarios and a randomized soak.
module tb_cnt_snapshot_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] cnt_in = '0;
  logic             trig = 1'b1;
  logic             clr_ovf = 1'b0;
  logic [AW:0]      level;
  logic             overflow;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  cnt_snapshot_fifo_if #(.WIDTH(WIDTH)) bus ();

  cnt_snapshot_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .trig     (trig),
    .clr_ovf  (clr_ovf),
    .level    (level),
    .overflow (overflow),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a bounded queue of captured values plus a sticky flag
  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf  = 1'b0;
  bit               m_prev = 1'b1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_prev = 1'b1;
    end else begin
      bit edge_seen;
      bit dropped;
      edge_seen = trig && !m_prev;
      m_prev    = trig;
      dropped   = 1'b0;
      if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
      if (edge_seen) begin
        if (m_q.size() < DEPTH) m_q.push_back(cnt_in);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_level", 32'(level), 32'(m_q.size()));
      check("model_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
      if (m_q.size() != 0) check("model_data", 32'(bus.out_data), 32'(m_q[0]));
    end
  end

  task automatic cyc(input bit t, input logic [WIDTH-1:0] c, input bit r, input bit cl = 1'b0);
    trig          = t;
    cnt_in        = c;
    bus.out_ready = r;
    clr_ovf       = cl;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [WIDTH-1:0] c);
    cyc(1'b1, c, 1'b0);
    cyc(1'b0, c + 8'd1, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_pops [4];
    logic [WIDTH-1:0] free_cnt;

    bus.out_ready = 1'b0;
    #1 rst = 1'b0;
    chk_en = 1'b1;
    cnt_in = 8'h10;
    trig   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_release_level", 32'(level), 32'd0);
    check("rst_release_valid", 32'(bus.out_valid), 32'd0);
    check("rst_release_ovf", 32'(overflow), 32'd0);

    // single capture into an empty FIFO
    cyc(1'b0, 8'h04, 1'b0);
    cyc(1'b1, 8'h05, 1'b0);
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_data", 32'(bus.out_data), 32'h05);
    check("single_level", 32'(level), 32'd1);
    cyc(1'b0, 8'h06, 1'b1);
    check("single_drained", 32'(level), 32'd0);

    // five captures into four slots
    pulse(8'd3); pulse(8'd6); pulse(8'd9); pulse(8'd12); pulse(8'd15);
    check("fill_level", 32'(level), 32'd4);
    check("fill_ovf", 32'(overflow), 32'd1);
    exp_pops = '{8'd3, 8'd6, 8'd9, 8'd12};
    for (int i = 0; i < 4; i++) begin
      check("fill_pop_data", 32'(bus.out_data), 32'(exp_pops[i]));
      cyc(1'b0, 8'h00, 1'b1);
    end
    check("fill_empty", 32'(bus.out_valid), 32'd0);

    // push and pop together while full
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_before_full", 32'(overflow), 32'd0);
    pulse(8'd1); pulse(8'd2); pulse(8'd3); pulse(8'd4);
    cyc(1'b1, 8'h40, 1'b1);
    check("fullpp_level", 32'(level), 32'd4);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    exp_pops = '{8'd2, 8'd3, 8'd4, 8'h40};
    for (int i = 0; i < 4; i++) begin
      check("fullpp_pop_data", 32'(bus.out_data), 32'(exp_pops[i]));
      cyc(1'b0, 8'h00, 1'b1);
    end

    // set wins over clear
    pulse(8'd7); pulse(8'd8); pulse(8'd9); pulse(8'd10);
    cyc(1'b1, 8'h77, 1'b0);
    check("drop_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h78, 1'b0);
    cyc(1'b1, 8'h79, 1'b0, 1'b1);
    check("set_wins_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h7A, 1'b0, 1'b1);
    check("clear_ovf", 32'(overflow), 32'd0);
    check("drop_kept_head", 32'(bus.out_data), 32'd7);
    repeat (4) cyc(1'b0, 8'h00, 1'b1);

    // captures across counter wrap, then asynchronous reset mid-stream
    cyc(1'b1, 8'hFE, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b0, 8'h02, 1'b0);
    check("wrap_level", 32'(level), 32'd2);
    check("wrap_head", 32'(bus.out_data), 32'hFE);
    #2 rst = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_data", 32'(bus.out_data), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    cyc(1'b0, 8'h03, 1'b1);
    cyc(1'b0, 8'h04, 1'b1);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_level", 32'(level), 32'd0);

    // randomized soak with a free-running count and occasional async reset
    free_cnt = 8'hF0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
      free_cnt = free_cnt + 8'd1;
      cyc(($urandom_range(0, 2) != 0),
          free_cnt,
          (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
